// File: rtl/db15_pkg.sv
// Shared definitions for the SNAC DB15 two-player serial reader:
// FSM states and the serial/MiSTer bit positions.
package db15_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    SHIFT_LO,
    SHIFT_HI,
    COMMIT
  } state_e;

  localparam int PAD_BITS = 12;

  // Order in which the adapter shifts each pad out
  localparam int SB_UP     = 0;
  localparam int SB_DOWN   = 1;
  localparam int SB_LEFT   = 2;
  localparam int SB_RIGHT  = 3;
  localparam int SB_A      = 4;
  localparam int SB_B      = 5;
  localparam int SB_C      = 6;
  localparam int SB_X      = 7;
  localparam int SB_Y      = 8;
  localparam int SB_Z      = 9;
  localparam int SB_START  = 10;
  localparam int SB_SELECT = 11;

  // MiSTer joystick word layout
  localparam int JB_RIGHT  = 0;
  localparam int JB_LEFT   = 1;
  localparam int JB_DOWN   = 2;
  localparam int JB_UP     = 3;
  localparam int JB_A      = 4;
  localparam int JB_START  = 5;
  localparam int JB_SELECT = 6;
  localparam int JB_B      = 7;
  localparam int JB_C      = 8;
  localparam int JB_X      = 9;
  localparam int JB_Y      = 10;
  localparam int JB_Z      = 11;

endpackage

// File: rtl/db15_remap.sv
// Combinational reorder of one pad's serial vector (pressed=1) into a
// MiSTer joystick word; upper nibble is always zero.
module db15_remap
  import db15_pkg::*;
(
  input  logic [PAD_BITS-1:0] pad_i,
  output logic [15:0]         joy_o
);

  always_comb begin
    joy_o            = '0;
    joy_o[JB_RIGHT]  = pad_i[SB_RIGHT];
    joy_o[JB_LEFT]   = pad_i[SB_LEFT];
    joy_o[JB_DOWN]   = pad_i[SB_DOWN];
    joy_o[JB_UP]     = pad_i[SB_UP];
    joy_o[JB_A]      = pad_i[SB_A];
    joy_o[JB_START]  = pad_i[SB_START];
    joy_o[JB_SELECT] = pad_i[SB_SELECT];
    joy_o[JB_B]      = pad_i[SB_B];
    joy_o[JB_C]      = pad_i[SB_C];
    joy_o[JB_X]      = pad_i[SB_X];
    joy_o[JB_Y]      = pad_i[SB_Y];
    joy_o[JB_Z]      = pad_i[SB_Z];
  end

endmodule

// File: rtl/db15_serial_pad.sv
// SNAC DB15 two-player reader: scans the adapter shift chain once per frame
// and publishes a pad state only when two consecutive frames agree.
module db15_serial_pad
  import db15_pkg::*;
#(
  parameter int DIV          = 24,
  parameter int GAP_CYCLES   = 4800,
  parameter int BITS_PER_PAD = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done
);

  localparam int FRAME_BITS = 2 * BITS_PER_PAD;
  localparam int CNT_MAX    = (DIV > GAP_CYCLES) ? DIV : GAP_CYCLES;
  localparam int CW         = $clog2(CNT_MAX);
  localparam int KW         = $clog2(FRAME_BITS);

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(FRAME_BITS - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [KW-1:0]         k_q, k_d;
  logic [1:0]            sync_q;
  logic [FRAME_BITS-1:0] frame_q, prev_q;
  logic [15:0]           joy1_q, joy2_q;
  logic [15:0]           joy1_new, joy2_new;
  logic                  sample;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
    end
  end

  // Every state restarts its count on entry, so one counter serves all.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    k_d     = k_q;
    case (state_q)
      IDLE:     if (cnt_q == GAP_LAST) begin state_d = LOAD; cnt_d = '0; end
      LOAD:     if (cnt_q == DIV_LAST) begin state_d = SETTLE; cnt_d = '0; end
      SETTLE:   if (cnt_q == DIV_LAST) begin
                  state_d = SHIFT_LO;
                  cnt_d   = '0;
                  k_d     = '0;
                end
      SHIFT_LO: if (cnt_q == DIV_LAST) begin state_d = SHIFT_HI; cnt_d = '0; end
      SHIFT_HI: if (cnt_q == DIV_LAST) begin
                  cnt_d = '0;
                  if (k_q == K_LAST) state_d = COMMIT;
                  else begin
                    k_d     = k_q + 1'b1;
                    state_d = SHIFT_LO;
                  end
                end
      COMMIT:   begin state_d = IDLE; cnt_d = '0; end
      default:  begin state_d = IDLE; cnt_d = '0; end
    endcase
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    JOY_CLK    = (state_q != SHIFT_LO);
    JOY_LOAD   = (state_q != LOAD);
    frame_done = (state_q == COMMIT) && enable;
  end

  assign sample = (state_q == SHIFT_LO) && (cnt_q == DIV_LAST);

  // Frames are held in pin sense (1 = released) so the reset value of
  // prev_q doubles as "all released".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b11;
      frame_q <= '1;
      prev_q  <= '1;
      joy1_q  <= '0;
      joy2_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], JOY_DATA};
      if (!enable) begin
        prev_q <= '1;
        joy1_q <= '0;
        joy2_q <= '0;
      end else begin
        if (sample) frame_q[k_q] <= sync_q[1];
        if (state_q == COMMIT) begin
          if (frame_q == prev_q) begin
            joy1_q <= joy1_new;
            joy2_q <= joy2_new;
          end
          prev_q <= frame_q;
        end
      end
    end
  end

  db15_remap u_remap_p1 (
    .pad_i (~frame_q[PAD_BITS-1:0]),
    .joy_o (joy1_new)
  );

  db15_remap u_remap_p2 (
    .pad_i (~frame_q[BITS_PER_PAD +: PAD_BITS]),
    .joy_o (joy2_new)
  );

  assign joystick1 = joy1_q;
  assign joystick2 = joy2_q;

endmodule

// File: tb/tb_db15_serial_pad.sv
// Scoreboard bench for db15_serial_pad: an adapter model serves queued
// pressed-button frames, a reference model predicts each committed word.
module tb_db15_serial_pad;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic        JOY_DATA = 1'b1;
  logic        JOY_CLK, JOY_LOAD, frame_done;
  logic [15:0] joystick1, joystick2;

  db15_serial_pad dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .JOY_DATA   (JOY_DATA),
    .JOY_CLK    (JOY_CLK),
    .JOY_LOAD   (JOY_LOAD),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  localparam logic [23:0] P_UP  = 24'h000001;
  localparam logic [23:0] P_R   = 24'h000008;
  localparam logic [23:0] P_A   = 24'h000010;
  localparam logic [23:0] P_Z   = 24'h000200;
  localparam logic [23:0] P2_ST = 24'h400000;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [23:0] pat_q[$];
  logic [31:0] exp_q[$];
  logic [23:0] cur_pat = '0;
  logic [4:0]  idx = '0;

  logic [23:0] prev_ref = '0;
  logic [15:0] out1_ref = '0;
  logic [15:0] out2_ref = '0;
  // MiSTer bit for each serial position Up,Down,Left,Right,A,B,C,X,Y,Z,Start,Select
  int pos_tab[12] = '{3, 2, 1, 0, 4, 7, 8, 9, 10, 11, 5, 6};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] map12(input logic [11:0] p);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 12; i++)
      if (p[i]) w = w | (16'd1 << pos_tab[i]);
    return w;
  endfunction

  // Two agreeing frames publish; every completed frame becomes the new reference.
  task automatic push_frame(input logic [23:0] pr, input bit completes);
    pat_q.push_back(pr);
    if (completes) begin
      if (pr == prev_ref) begin
        out1_ref = map12(pr[11:0]);
        out2_ref = map12(pr[23:12]);
      end
      prev_ref = pr;
      exp_q.push_back({out1_ref, out2_ref});
    end
  endtask

  task automatic model_clear();
    prev_ref = '0;
    out1_ref = '0;
    out2_ref = '0;
  endtask

  // Adapter: parallel load on JOY_LOAD low, advance on JOY_CLK rising, active-low pins.
  always @(negedge JOY_LOAD or posedge JOY_CLK) begin
    if (!JOY_LOAD) begin
      cur_pat  = (pat_q.size() > 0) ? pat_q.pop_front() : 24'h0;
      idx      = '0;
      JOY_DATA = ~cur_pat[0];
    end else begin
      if (idx != 5'd31) idx = idx + 5'd1;
      JOY_DATA = (idx < 5'd24) ? ~cur_pat[idx] : 1'b1;
    end
  end

  // Monitor: on each frame_done the published words are checked one cycle later.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        done_cnt++;
        @(negedge clk);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame_done frame=%0d", done_cnt);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("frame%0d_joystick1", done_cnt), {16'h0, joystick1}, {16'h0, e[31:16]});
          check($sformatf("frame%0d_joystick2", done_cnt), {16'h0, joystick2}, {16'h0, e[15:0]});
        end
      end
    end
  end

  task automatic gap_to_load(output int n, output bit clk_ok);
    n = 0;
    clk_ok = 1'b1;
    while (JOY_LOAD !== 1'b0 && n < 7000) begin
      if (JOY_CLK !== 1'b1) clk_ok = 1'b0;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 70000) begin
      @(negedge clk);
      n++;
    end
    check("frames_completed", done_cnt, target);
  endtask

  // Called during LOAD; returns at the first sample of SHIFT_LO for bit bit_k.
  task automatic wait_shift_lo(input int bit_k);
    int   falls, n;
    logic prevc;
    falls = 0;
    n = 0;
    prevc = 1'b1;
    while (falls < bit_k + 1 && n < 3000) begin
      @(negedge clk);
      n++;
      if (prevc && !JOY_CLK) falls++;
      prevc = JOY_CLK;
    end
    check("reach_shift_lo", falls, bit_k + 1);
  endtask

  initial begin
    int          n, low, falls, first_fall, last_fall, snap;
    bit          ok;
    logic        prevc;
    logic [23:0] r;

    push_frame(24'h0, 1);
    push_frame(P_UP, 1);
    push_frame(P_UP, 1);
    push_frame(P_UP | P2_ST, 1);
    push_frame(P_UP | P2_ST, 1);
    push_frame(P_UP, 1);
    push_frame(P_UP, 1);
    push_frame(P_A | P_R, 1);
    push_frame(P_A | P_R, 1);
    push_frame(P_A | P_R | P_Z, 1);
    push_frame(P_A | P_R, 0);

    #2 reset_n = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_JOY_CLK", {31'h0, JOY_CLK}, 32'h1);
    check("rst_JOY_LOAD", {31'h0, JOY_LOAD}, 32'h1);
    check("rst_joystick1", {16'h0, joystick1}, 32'h0);
    check("rst_joystick2", {16'h0, joystick2}, 32'h0);
    check("rst_frame_done", {31'h0, frame_done}, 32'h0);
    reset_n = 1'b1;

    gap_to_load(n, ok);
    check("first_gap_cycles", n, 4800);
    check("gap_clk_high", {31'h0, ok}, 32'h1);
    n = 0;
    while (JOY_LOAD === 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("load_low_cycles", n, 24);

    n = 0; low = 0; falls = 0; first_fall = 0; last_fall = 0; prevc = 1'b1;
    while (frame_done !== 1'b1 && n < 2000) begin
      if (!JOY_CLK) low++;
      if (prevc && !JOY_CLK) begin
        if (falls == 0) first_fall = n;
        last_fall = n;
        falls++;
      end
      prevc = JOY_CLK;
      n++;
      @(negedge clk);
    end
    check("frame_done_cycle", 4800 + 24 + n + 1, 6001);
    check("clk_periods", falls, 24);
    check("clk_low_cycles", low, 24 * 24);
    check("clk_period_span", last_fall - first_fall, 23 * 48);

    wait_done(10);

    // Abort mid-scan with non-zero outputs.
    gap_to_load(n, ok);
    wait_shift_lo(10);
    repeat (5) @(negedge clk);
    check("pre_abort_joystick1", {16'h0, joystick1}, {16'h0, out1_ref});
    snap = done_cnt;
    enable = 1'b0;
    @(negedge clk);
    model_clear();
    check("abort_JOY_CLK", {31'h0, JOY_CLK}, 32'h1);
    check("abort_JOY_LOAD", {31'h0, JOY_LOAD}, 32'h1);
    check("abort_joystick1", {16'h0, joystick1}, 32'h0);
    check("abort_joystick2", {16'h0, joystick2}, 32'h0);
    check("abort_frame_done", {31'h0, frame_done}, 32'h0);
    repeat (100) @(negedge clk);
    check("abort_no_commit", done_cnt, snap);

    r = 24'($urandom) | P_UP;
    push_frame(r, 1);
    push_frame(r, 1);
    enable = 1'b1;
    gap_to_load(n, ok);
    check("reenable_gap_cycles", n, 4800);
    wait_done(12);

    // Asynchronous reset during SHIFT_HI of bit 0.
    pat_q.push_back(24'($urandom));
    gap_to_load(n, ok);
    wait_shift_lo(0);
    n = 0;
    while (JOY_CLK !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_joystick1", {16'h0, joystick1}, {16'h0, out1_ref});
    #3 reset_n = 1'b0;
    #1;
    model_clear();
    check("async_rst_JOY_CLK", {31'h0, JOY_CLK}, 32'h1);
    check("async_rst_JOY_LOAD", {31'h0, JOY_LOAD}, 32'h1);
    check("async_rst_joystick1", {16'h0, joystick1}, 32'h0);
    check("async_rst_joystick2", {16'h0, joystick2}, 32'h0);
    check("async_rst_frame_done", {31'h0, frame_done}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    gap_to_load(n, ok);
    check("post_reset_gap_cycles", n, 4800);
    check("post_reset_no_commit", done_cnt, 12);
    check("post_reset_joystick1", {16'h0, joystick1}, {16'h0, out1_ref});
    check("post_reset_joystick2", {16'h0, joystick2}, {16'h0, out2_ref});
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
